// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU issue controller:
//   - op-code constants for the combinational FPU datapath
//   - issue FSM state encoding
//   - lat_of():  per-op cycle allotment
//   - max_lat(): largest allotment, used to size the latency counter
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam logic [3:0] FPU_OP_ADDSUB = 4'd0;
  localparam logic [3:0] FPU_OP_MUL    = 4'd1;
  localparam logic [3:0] FPU_OP_DIV    = 4'd2;
  localparam logic [3:0] FPU_OP_MINMAX = 4'd3;
  localparam logic [3:0] FPU_OP_CMP    = 4'd4;
  localparam logic [3:0] FPU_OP_SGNJ   = 4'd5;
  localparam logic [3:0] FPU_OP_CVT    = 4'd6;
  localparam logic [3:0] FPU_OP_ICVT   = 4'd7;

  // Op driven to the datapath while an illegal op is being reported.
  localparam logic [3:0] FPU_OP_NONE   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } fpu_state_e;

  // Cycles allotted to a legal op. Illegal codes fall into the default
  // branch, but the caller never loads the counter for them.
  function automatic int lat_of(input logic [3:0] op,
                                input int lat_addsub,
                                input int lat_mul,
                                input int lat_div,
                                input int lat_other);
    case (op)
      FPU_OP_ADDSUB: lat_of = lat_addsub;
      FPU_OP_MUL:    lat_of = lat_mul;
      FPU_OP_DIV:    lat_of = lat_div;
      default:       lat_of = lat_other;
    endcase
  endfunction

  function automatic int max_lat(input int a, input int b,
                                 input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    max_lat = m;
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// ---------------------------------------------------------------------------
// fpu_lat_counter
// Loadable down-counter that times how long the operands are held on the
// multicycle datapath. Load wins over decrement; decrement stops at zero.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           load i_load_val this edge
//   i_load_val       value loaded (latency - 1)
//   i_dec            decrement request (ignored when already zero)
//   o_zero           counter is zero
// ---------------------------------------------------------------------------
module fpu_lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Sequencing controller in front of the combinational FPU datapath. Accepts
// one op at a time, holds its operands stable for a per-op number of cycles
// (multicycle paths), captures the result and presents it with its tag.
// Ports:
//   in_clk, in_rst_n                     clock, asynchronous active-low reset
//   in_req_*/out_req_ready               request port (valid/ready)
//   in_flush                             abort in-flight op / pending result
//   out_fpu_*                            registered operands/controls to datapath
//   in_fpu_result                        datapath result
//   out_res_*/in_res_ready               response port (valid/ready)
//   out_busy                             FSM not idle
//   out_op_count                         consumed-result counter (wraps)
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5,
  parameter int LAT_ADDSUB = 2,
  parameter int LAT_MUL    = 3,
  parameter int LAT_DIV    = 8,
  parameter int LAT_OTHER  = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic [3:0]            in_req_op,
  input  logic                  in_req_fmt,
  input  logic                  in_req_output_fmt,
  input  logic [DATA_WIDTH-1:0] in_req_rs1,
  input  logic [DATA_WIDTH-1:0] in_req_rs2,
  input  logic [TAG_WIDTH-1:0]  in_req_tag,
  input  logic                  in_flush,
  output logic [DATA_WIDTH-1:0] out_fpu_rs1,
  output logic [DATA_WIDTH-1:0] out_fpu_rs2,
  output logic [3:0]            out_fpu_op,
  output logic                  out_fpu_fmt,
  output logic                  out_fpu_output_fmt,
  input  logic [DATA_WIDTH-1:0] in_fpu_result,
  output logic                  out_res_valid,
  input  logic                  in_res_ready,
  output logic [DATA_WIDTH-1:0] out_res_data,
  output logic [TAG_WIDTH-1:0]  out_res_tag,
  output logic                  out_res_illegal,
  output logic                  out_busy,
  output logic [15:0]           out_op_count
);

  localparam int LAT_MAX = max_lat(LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_OTHER);
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  fpu_state_e r_state;
  fpu_state_e w_state_nxt;

  logic [DATA_WIDTH-1:0] r_rs1;
  logic [DATA_WIDTH-1:0] r_rs2;
  logic [3:0]            r_op;
  logic                  r_fmt;
  logic                  r_output_fmt;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_illegal;
  logic [15:0]           r_op_count;

  logic             w_req_illegal;
  logic             w_accept;
  logic             w_consume;
  logic             w_capture;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_lat_m1;

  assign w_req_illegal = in_req_op[3];
  assign w_lat_m1      = CNT_W'(lat_of(in_req_op, LAT_ADDSUB, LAT_MUL,
                                       LAT_DIV, LAT_OTHER) - 1);

  // Ready depends only on state, flush and the response-side ready, so a
  // finishing result and a new request can hand off in the same cycle.
  assign out_req_ready = !in_flush &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_DONE) && in_res_ready));

  assign w_accept  = in_req_valid && out_req_ready;
  assign w_consume = (r_state == ST_DONE) && in_res_ready && !in_flush;
  assign w_capture = (r_state == ST_EXEC) && w_cnt_zero && !in_flush;

  fpu_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .i_clk      (in_clk),
    .i_rst_n    (in_rst_n),
    .i_load     (w_accept && !w_req_illegal),
    .i_load_val (w_lat_m1),
    .i_dec      (r_state == ST_EXEC),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_req_illegal ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        if (in_flush)        w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (in_flush)          w_state_nxt = ST_IDLE;
        else if (w_accept)     w_state_nxt = w_req_illegal ? ST_DONE : ST_EXEC;
        else if (in_res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/control registers: written only on accept, so they stay
  // constant on the datapath for the whole EXEC window.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_op         <= '0;
      r_fmt        <= 1'b0;
      r_output_fmt <= 1'b0;
      r_tag        <= '0;
    end else if (w_accept) begin
      r_rs1        <= in_req_rs1;
      r_rs2        <= in_req_rs2;
      r_op         <= w_req_illegal ? FPU_OP_NONE : in_req_op;
      r_fmt        <= in_req_fmt;
      r_output_fmt <= in_req_output_fmt;
      r_tag        <= in_req_tag;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_res_data    <= '0;
      r_res_illegal <= 1'b0;
    end else if (w_accept && w_req_illegal) begin
      r_res_data    <= '0;
      r_res_illegal <= 1'b1;
    end else if (w_capture) begin
      r_res_data    <= in_fpu_result;
      r_res_illegal <= 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_op_count <= '0;
    end else if (w_consume) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign out_fpu_rs1        = r_rs1;
  assign out_fpu_rs2        = r_rs2;
  assign out_fpu_op         = r_op;
  assign out_fpu_fmt        = r_fmt;
  assign out_fpu_output_fmt = r_output_fmt;
  assign out_res_valid      = (r_state == ST_DONE);
  assign out_res_data       = r_res_data;
  assign out_res_tag        = r_tag;
  assign out_res_illegal    = r_res_illegal;
  assign out_busy           = (r_state != ST_IDLE);
  assign out_op_count       = r_op_count;

endmodule
